// File: rtl/lab2_proc_int_mul_pipe.sv
//==============================================================================
// Module      : lab2_proc_int_mul_pipe
// Description : Fully pipelined integer multiplier with val/rdy streams on both
//               sides. Supports the four RISC-V M-extension multiply modes
//               (mul, mulh, mulhsu, mulhu). Accepts one operation per cycle,
//               returns results in acceptance order and reports the number of
//               occupied pipeline stages.
//
// Ports       : clk              - clock, all state updates on rising edge
//               reset            - asynchronous reset, active low
//               istream_val/rdy  - request handshake
//               istream_msg_a    - operand a (rs1), p_width bits
//               istream_msg_b    - operand b (rs2), p_width bits
//               istream_msg_mode - 00 mul, 01 mulh, 10 mulhsu, 11 mulhu
//               ostream_val/rdy  - result handshake
//               ostream_msg      - result, p_width bits
//               occupancy        - count of valid pipeline stages
//
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module lab2_proc_int_mul_pipe #(
    parameter int p_width  = 32,
    parameter int p_stages = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            istream_val,
    output logic                            istream_rdy,
    input  logic [p_width-1:0]              istream_msg_a,
    input  logic [p_width-1:0]              istream_msg_b,
    input  logic [1:0]                      istream_msg_mode,
    output logic                            ostream_val,
    input  logic                            ostream_rdy,
    output logic [p_width-1:0]              ostream_msg,
    output logic [$clog2(p_stages+1)-1:0]   occupancy
);

    localparam int         c_occ_w       = $clog2(p_stages + 1);
    localparam int         c_last        = p_stages - 1;
    localparam int         c_prod_w      = 2 * p_width;
    localparam logic [1:0] c_mode_mul    = 2'b00;
    localparam logic [1:0] c_mode_mulh   = 2'b01;
    localparam logic [1:0] c_mode_mulhsu = 2'b10;

    //--------------------------------------------------------------------------
    // Product of the extended operands. Extending both operands to 2*p_width
    // bits and keeping the low 2*p_width bits of their product yields the exact
    // double-width result for every signedness combination.
    //--------------------------------------------------------------------------
    logic                w_a_signed;
    logic                w_b_signed;
    logic [c_prod_w-1:0] w_a_ext;
    logic [c_prod_w-1:0] w_b_ext;
    logic [c_prod_w-1:0] w_product;

    always_comb begin
        w_a_signed = (istream_msg_mode == c_mode_mulh) ||
                     (istream_msg_mode == c_mode_mulhsu);
        w_b_signed = (istream_msg_mode == c_mode_mulh);
        w_a_ext    = {{p_width{w_a_signed & istream_msg_a[p_width-1]}}, istream_msg_a};
        w_b_ext    = {{p_width{w_b_signed & istream_msg_b[p_width-1]}}, istream_msg_b};
        w_product  = w_a_ext * w_b_ext;
    end

    //--------------------------------------------------------------------------
    // Valid bits, load enables and occupancy.
    // w_load[k] : stage k captures its predecessor this cycle.
    // w_val_in[k]: valid bit offered to stage k by its predecessor.
    // The load chain is evaluated from the output side backwards so a stall
    // only propagates up to the first empty stage (bubbles collapse).
    //--------------------------------------------------------------------------
    logic [p_stages-1:0] r_val;
    logic [p_stages-1:0] w_load;
    logic [p_stages-1:0] w_val_in;
    logic [p_stages-1:0] w_val_next;
    logic [c_occ_w-1:0]  w_cnt;
    logic [c_occ_w-1:0]  r_occ;

    always_comb begin
        w_load         = '0;
        w_val_in       = '0;
        w_load[c_last] = !r_val[c_last] || ostream_rdy;
        for (int k = c_last - 1; k >= 0; k--) begin
            w_load[k] = !r_val[k] || w_load[k+1];
        end
        w_val_in[0] = istream_val;
        for (int k = 1; k < p_stages; k++) begin
            w_val_in[k] = r_val[k-1];
        end
        w_val_next = r_val;
        w_cnt      = '0;
        for (int k = 0; k < p_stages; k++) begin
            if (w_load[k]) begin
                w_val_next[k] = w_val_in[k];
            end
            w_cnt = w_cnt + c_occ_w'(w_val_next[k]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_val <= '0;
            r_occ <= '0;
        end else begin
            r_val <= w_val_next;
            r_occ <= w_cnt;
        end
    end

    //--------------------------------------------------------------------------
    // Data path. Intermediate stages carry the full product and the mode; the
    // half selection happens when the final stage loads, so the output is
    // driven straight from a register.
    //--------------------------------------------------------------------------
    logic [c_prod_w-1:0] w_in_prod [p_stages];
    logic [1:0]          w_in_mode [p_stages];

    assign w_in_prod[0] = w_product;
    assign w_in_mode[0] = istream_msg_mode;

    generate
        for (genvar k = 0; k < c_last; k++) begin : g_mid_stage
            logic [c_prod_w-1:0] r_prod;
            logic [1:0]          r_mode;

            // Data only moves with a valid entry, leaving empty stages quiet.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_prod <= '0;
                    r_mode <= '0;
                end else if (w_load[k] && w_val_in[k]) begin
                    r_prod <= w_in_prod[k];
                    r_mode <= w_in_mode[k];
                end
            end

            assign w_in_prod[k+1] = r_prod;
            assign w_in_mode[k+1] = r_mode;
        end
    endgenerate

    logic [p_width-1:0] w_result;
    logic [p_width-1:0] r_msg;

    always_comb begin
        if (w_in_mode[c_last] == c_mode_mul) begin
            w_result = w_in_prod[c_last][p_width-1:0];
        end else begin
            w_result = w_in_prod[c_last][c_prod_w-1:p_width];
        end
    end

    // Holds its last value while the stage is empty.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_msg <= '0;
        end else if (w_load[c_last] && w_val_in[c_last]) begin
            r_msg <= w_result;
        end
    end

    assign istream_rdy = w_load[0];
    assign ostream_val = r_val[c_last];
    assign ostream_msg = r_msg;
    assign occupancy   = r_occ;

endmodule

`default_nettype wire

// File: doc/lab2_proc_int_mul_pipe.md
# lab2_proc_int_mul_pipe

Parametrised, fully pipelined integer multiplier with latency-insensitive val/rdy streams on both sides. It is the next-generation replacement for the fixed-latency multiplier attached to the processor datapath's multiplier request/response ports. Width and depth are configurable, and it supports all four RISC-V M-extension multiply modes. Accepts one operation per cycle, returns results in order, and reports live pipeline occupancy to the control unit.

## Interface
- p_width, 32: operand and result width in bits (≥ 2).
- p_stages, 4: pipeline depth, meaning register stages from accept to result (1..8).
- clk  in  1  clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- istream_val  in  1  request valid.
- istream_rdy  out  1  request ready.
- istream_msg_a  in  p_width  operand a (rs1).
- istream_msg_b  in  p_width  operand b (rs2).
- istream_msg_mode  in  2  00 mul, 01 mulh, 10 mulhsu, 11 mulhu.
- ostream_val  out  1  result valid.
- ostream_rdy  in  1  result ready.
- ostream_msg  out  p_width  result.
- occupancy  out  $clog2(p_stages+1)  number of valid entries in the pipeline.

## Operation
- Each stage k (0..p_stages-1) holds one valid bit plus data registers. Stage 0 captures the request; stage p_stages-1 drives the ostream outputs directly from registers.
- Stage advance rule:
  - Stage p_stages-1 may load iff it is empty or (ostream_val && ostream_rdy).
  - Stage k < p_stages-1 may load iff it is empty or stage k+1 may load.
  - The ready chain is combinational, so bubbles collapse.
- istream_rdy = stage 0 may load. The transfer happens iff istream_val && istream_rdy. When a stage loads from an empty predecessor, its valid bit clears.
- Arithmetic is computed as an exact 2·p_width-bit product of extended operands:
  - mul: low p_width bits; signedness is irrelevant.
  - mulh: a signed × b signed, high p_width bits.
  - mulhsu: a signed × b unsigned, high p_width bits.
  - mulhu: a unsigned × b unsigned, high p_width bits.
- Partitioning of the partial-product work across stages is implementation-defined. The result must be bit-exact for every mode, width and depth.
- The mode travels with the data and is applied at the stage where the half is selected. There are no mode changes in flight.
- occupancy = population count of the stage valid bits, registered, with the same update edge as the valid bits.
- Results leave in strict acceptance order. No drop and no duplication under any val/rdy pattern.

## Timing
- Reset asserted (reset=0):
  - Immediately and asynchronously: all valid bits 0, all data registers 0.
  - Outputs: ostream_val=0, ostream_msg=0, occupancy=0.
  - istream_rdy=1 combinationally.
- Reset mid-operation discards all in-flight operations. No stale result appears after deassertion.
- Latency: a request accepted at edge t is presented on ostream_val/ostream_msg after edge t+p_stages-1, i.e. in the p_stages-th cycle counting the accept cycle as cycle 1. With p_stages=1, the result is visible in the cycle after acceptance.
- Throughput: 1 op/cycle while ostream_rdy=1.
- Full (occupancy=p_stages):
  - istream_rdy = ostream_rdy.
  - Simultaneous accept and drain in one cycle is legal; occupancy stays p_stages.
- Empty: ostream_val=0. ostream_msg holds its last value, which is don't-care.
- ostream_val/ostream_msg are stable while ostream_val=1 && ostream_rdy=0.
- Combinational paths:
  - Only path is ostream_rdy → istream_rdy.
  - No path from istream_val to istream_rdy or to any output.

## Test plan
- Reset and idle (p_width=32, p_stages=4): reset=0 mid-cycle → ostream_val=0, occupancy=0, istream_rdy=1 immediately. Hold reset=1 for 10 idle cycles → ostream_val stays 0.
- Mode correctness, all four modes, ostream_rdy=1, expected result 4 cycles after accept:
  - a=3, b=7, mode 00 → 0x00000015.
  - a=0xFFFFFFFF, b=0xFFFFFFFF: mode 00 → 0x00000001; mode 01 → 0x00000000; mode 10 → 0xFFFFFFFF; mode 11 → 0xFFFFFFFE.
  - a=0x80000000, b=0x80000000, mode 01 → 0x40000000.
- Back-to-back streaming: 20 random ops with ostream_rdy=1 → one result per cycle after a 4-cycle fill, in order, matching a golden model.
- Backpressure: 6 ops sent, ostream_rdy=0 from cycle 2 → occupancy reaches 4, istream_rdy=0, ostream_msg stable. Release ostream_rdy → all 6 delivered in order, none lost.
- Simultaneous events and bubbles: full pipe, ostream_rdy=1 and istream_val=1 → accept every cycle, occupancy constant at 4. Random val/rdy toggling → bubbles collapse, order preserved.
- Parametrisation and reset mid-stream: rerun the mode and streaming tests with (p_width=16, p_stages=1) and (p_width=64, p_stages=8). Assert reset=0 with occupancy=3 → no result emitted after release, occupancy=0.
